period_meter: RTL

Measures an incoming slow square wave, such as a divided 1 Hz clock, against the system clock. It reports the period and high time of each cycle in system-clock counts and flags the input as stale when no edge arrives in time. It is the receiving end of the clock divider: the divider turns a count into a frequency, and this block turns a frequency back into a count. Its outputs feed on-board self-check logic and display logic in the stopwatch design.

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/period_meter_if.sv | 29 ++
 rtl/period_meter_sync_rise_detect.sv | 30 +++
 rtl/period_meter.sv | 107 ++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: FSM state encoding and the system
// clock rate, which the clock divider also uses.
package period_meter_pkg;

  localparam int unsigned SYSCLK_HZ = 50_000_000;
  localparam int unsigned DEFAULT_WIDTH = 28;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_STALE   = 2'd2;

endpackage

// File: rtl/period_meter_if.sv
// Bundle of the measured input and the measurement results. The master side
// drives sig_in and reads results; the slave (the meter) does the opposite.
interface period_meter_if #(
  parameter int unsigned WIDTH = period_meter_pkg::DEFAULT_WIDTH
);

  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stale;

  modport master (
    output sig_in,
    input  period,
    input  high_time,
    input  valid,
    input  stale
  );

  modport slave (
    input  sig_in,
    output period,
    output high_time,
    output valid,
    output stale
  );

endinterface

// File: rtl/period_meter_sync_rise_detect.sv
// Two-flop synchronizer plus edge detector. All flops reset high so a line
// that is already high when reset releases never reports a rising edge.
module sync_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow input in system-clock cycles and
// flags the input stale when no rising edge shows up within TIMEOUT cycles.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(2 * SYSCLK_HZ)
) (
  input  logic           clock,
  input  logic           reset,
  period_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic level;
  logic rise;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] hcnt_q,   hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q,   high_d;
  logic             valid_q,  valid_d;
  logic             stale_q,  stale_d;

  sync_rise_detect u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (bus.sig_in),
    .level_o (level),
    .rise_o  (rise)
  );

  // A rise always wins over the timeout, so a period of exactly TIMEOUT is
  // still reported; counters saturate at TIMEOUT and can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    stale_d  = stale_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (rise) begin
          cnt_d   = ONE;
          hcnt_d  = ONE;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          cnt_d    = ONE;
          hcnt_d   = ONE;
        end else if (cnt_q == TIMEOUT) begin
          state_d = ST_STALE;
          stale_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + ONE;
          hcnt_d = hcnt_q + WIDTH'(level);
        end
      end
      ST_STALE: begin
        if (rise) begin
          stale_d = 1'b0;
          cnt_d   = ONE;
          hcnt_d  = ONE;
          state_d = ST_MEASURE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stale_q  <= stale_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.stale     = stale_q;

endmodule
